// File: rtl/exec_control.sv
// Debug execution controller: debounces step/run/halt/burst buttons and sequences the
// core clock enable through HALT, STEP, RUN and N-cycle BURST with a PC breakpoint.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_HALT  | core stopped, waiting for a step, run or burst press
// ST_STEP  | one enabled cycle, then back to HALT
// ST_RUN   | free running until a halt press or breakpoint match
// ST_BURST | runs r_cnt enabled cycles, stops early on halt press or breakpoint
module exec_control #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PC_W            = 32,
    parameter int NCYC_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_btn_step,
    input  logic              i_btn_run,
    input  logic              i_btn_halt,
    input  logic              i_btn_burst,
    input  logic [NCYC_W-1:0] i_burst_n,
    input  logic              i_bp_en,
    input  logic [PC_W-1:0]   i_bp_addr,
    input  logic [PC_W-1:0]   i_pc,
    output logic              o_cpu_ce,
    output logic              o_halted,
    output logic [1:0]        o_state,
    output logic              o_bp_hit,
    output logic [31:0]       o_cycle_count
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BURST = 2'b11
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

    // bit order: 0 step, 1 run, 2 halt, 3 burst
    logic [3:0]      w_btn;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_deb;
    logic [3:0]      r_deb_q;
    logic [3:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [4];

    assign w_btn = {i_btn_burst, i_btn_halt, i_btn_run, i_btn_step};

    // Down-counter reloads whenever the synced level agrees with the debounced one,
    // so only an unbroken run of DEBOUNCE_CYCLES differing samples reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            r_press <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= DB_LOAD;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= DB_LOAD;
                end else if (r_db_cnt[i] == '0) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= DB_LOAD;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] - 1'b1;
                end
            end
            r_deb_q <= r_deb;
            r_press <= r_deb & ~r_deb_q;
        end
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NCYC_W-1:0] r_cnt;
    logic [NCYC_W-1:0] w_cnt_nxt;
    logic              r_first;
    logic              w_first_nxt;
    logic              r_bp_hit;
    logic              w_bp_hit_nxt;
    logic [31:0]       r_cycle_count;
    logic              w_cpu_ce;
    logic              w_bp_match;
    logic              w_halt_p;
    logic              w_step_p;
    logic              w_run_p;
    logic              w_burst_p;

    assign w_halt_p  = r_press[2];
    assign w_step_p  = r_press[0] & ~r_press[2];
    assign w_run_p   = r_press[1] & ~r_press[2] & ~r_press[0];
    assign w_burst_p = r_press[3] & ~r_press[2] & ~r_press[0] & ~r_press[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HALT;
            r_cnt         <= '0;
            r_first       <= 1'b0;
            r_bp_hit      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_first  <= w_first_nxt;
            r_bp_hit <= w_bp_hit_nxt;
            if (w_cpu_ce) r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_first_nxt  = 1'b0;
        w_bp_hit_nxt = r_bp_hit;
        // first suppresses the match so execution can resume from the breakpoint address
        w_bp_match   = i_bp_en && (i_pc == i_bp_addr) && !r_first &&
                       (r_state == ST_RUN || r_state == ST_BURST);
        w_cpu_ce     = (r_state == ST_STEP) ||
                       ((r_state == ST_RUN || r_state == ST_BURST) && !w_bp_match);
        case (r_state)
            ST_HALT: begin
                if (w_step_p) begin
                    w_state_nxt  = ST_STEP;
                    w_bp_hit_nxt = 1'b0;
                end else if (w_run_p) begin
                    w_state_nxt  = ST_RUN;
                    w_first_nxt  = 1'b1;
                    w_bp_hit_nxt = 1'b0;
                end else if (w_burst_p && i_burst_n != '0) begin
                    w_state_nxt  = ST_BURST;
                    w_cnt_nxt    = i_burst_n;
                    w_first_nxt  = 1'b1;
                    w_bp_hit_nxt = 1'b0;
                end
            end
            ST_STEP: w_state_nxt = ST_HALT;
            ST_RUN: begin
                if (w_halt_p) begin
                    w_state_nxt = ST_HALT;
                end else if (w_bp_match) begin
                    w_state_nxt  = ST_HALT;
                    w_bp_hit_nxt = 1'b1;
                end
            end
            ST_BURST: begin
                if (w_halt_p) begin
                    w_state_nxt = ST_HALT;
                end else if (w_bp_match) begin
                    w_state_nxt  = ST_HALT;
                    w_bp_hit_nxt = 1'b1;
                end else if (w_cpu_ce) begin
                    w_cnt_nxt = r_cnt - NCYC_W'(1);
                    if (r_cnt == NCYC_W'(1)) w_state_nxt = ST_HALT;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    assign o_cpu_ce      = w_cpu_ce;
    assign o_halted      = (r_state == ST_HALT);
    assign o_state       = r_state;
    assign o_bp_hit      = r_bp_hit;
    assign o_cycle_count = r_cycle_count;

endmodule
